seq_ctrl: RTL and testbench

SEQ_CTRL -- requirements
Module: seq_ctrl

---
 rtl/seq_ctrl_pkg.sv | 27 ++
 rtl/seq_ctrl_step_counter.sv | 51 +++++
 rtl/seq_ctrl.sv | 131 +++++++++++++
 tb/tb_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_ctrl_pkg
// Shared CPU sequencer definitions: FSM state codes, micro-step and
// instruction-counter widths, and a small helper for the step ceiling.
// No ports (package).
// -----------------------------------------------------------------------------
package seq_ctrl_pkg;

  localparam int STEP_W  = 4;
  localparam int CNT_W   = 16;
  localparam int STATE_W = 3;

  localparam logic [STEP_W-1:0] STEP_MAX = 4'd15;

  // FSM state codes, visible to the control unit through state_o
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN    = 3'd1;
  localparam logic [STATE_W-1:0] ST_PAUSE  = 3'd2;
  localparam logic [STATE_W-1:0] ST_HALTED = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAULT  = 3'd4;

  // True when one more increment would overflow the micro-step counter
  function automatic logic stepAtMax(input logic [STEP_W-1:0] stepVal);
    return stepVal == STEP_MAX;
  endfunction

endpackage

// File: rtl/seq_ctrl_step_counter.sv
// -----------------------------------------------------------------------------
// step_counter
// Micro-step counter plus completed-instruction counter. The owning FSM
// decides which single operation happens on each edge.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   i_clear        force step to 0, count unchanged (restart after halt/fault)
//   i_inc          advance step by one
//   i_complete     instruction done: step to 0, count + 1 (wraps)
//   o_step         current micro-step
//   o_count        completed-instruction count
// -----------------------------------------------------------------------------
module step_counter
  import seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_inc,
  input  logic              i_complete,
  output logic [STEP_W-1:0] o_step,
  output logic [CNT_W-1:0]  o_count
);

  localparam logic [STEP_W-1:0] STEP_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

  logic [STEP_W-1:0] r_step;
  logic [CNT_W-1:0]  r_count;

  // Clear outranks completion, which outranks increment; the FSM never
  // asserts more than one, the ordering just keeps the behaviour defined.
  // The instruction counter wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_step  <= '0;
    end else if (i_complete) begin
      r_step  <= '0;
      r_count <= r_count + CNT_ONE;
    end else if (i_inc) begin
      r_step  <= r_step + STEP_ONE;
    end
  end

  assign o_step  = r_step;
  assign o_count = r_count;

endmodule

// File: rtl/seq_ctrl.sv
// -----------------------------------------------------------------------------
// seq_ctrl
// CPU sequencer: run/pause/halt/fault FSM driving the micro-step counter.
// Ports:
//   clk, rst_n     clock (rising edge), async active-low reset
//   start          pulse: begin or resume execution
//   stop           pulse: pause at the next instruction boundary
//   single_mode    level: pause after every instruction
//   sc_inc         step-advance request (honoured only in RUN)
//   sc_reset       instruction complete (honoured only in RUN)
//   halt           HLT executed (honoured only in RUN)
//   step           current micro-step to the control unit
//   cpu_run        registered execution enable (1 only in RUN)
//   state_o        encoded FSM state
//   halted, fault  registered state flags
//   instr_count    completed-instruction counter
// -----------------------------------------------------------------------------
module seq_ctrl
  import seq_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               single_mode,
  input  logic               sc_inc,
  input  logic               sc_reset,
  input  logic               halt,
  output logic [STEP_W-1:0]  step,
  output logic               cpu_run,
  output logic [STATE_W-1:0] state_o,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   instr_count
);

  logic [STATE_W-1:0] r_state;
  logic               r_stopPending;
  logic               r_cpuRun;
  logic               r_halted;
  logic               r_fault;

  logic [STATE_W-1:0] w_nextState;
  logic               w_stopPendingNext;
  logic               w_clear;
  logic               w_inc;
  logic               w_complete;
  logic               w_startAccepted;
  logic [STEP_W-1:0]  w_step;
  logic [CNT_W-1:0]   w_count;

  // A stop on the same edge as start vetoes the start
  assign w_startAccepted = start & ~stop;

  // Next-state and counter control. Control-unit inputs are only looked at
  // in RUN; elsewhere only start can move the FSM. Pausing is decided only
  // at an sc_reset boundary so an instruction is never cut short.
  always_comb begin
    w_nextState = r_state;
    w_clear     = 1'b0;
    w_inc       = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE, ST_PAUSE: begin
        if (w_startAccepted) w_nextState = ST_RUN;
      end
      ST_HALTED, ST_FAULT: begin
        if (w_startAccepted) begin
          w_nextState = ST_RUN;
          w_clear     = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt) begin
          w_nextState = ST_HALTED;
        end else if (sc_reset) begin
          w_complete = 1'b1;
          if (single_mode || r_stopPending) w_nextState = ST_PAUSE;
        end else if (sc_inc) begin
          if (stepAtMax(w_step)) w_nextState = ST_FAULT;
          else                   w_inc       = 1'b1;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // The stop request is remembered only while execution continues; any
  // exit from RUN consumes or discards it.
  always_comb begin
    w_stopPendingNext = r_stopPending;
    if (w_nextState != ST_RUN)            w_stopPendingNext = 1'b0;
    else if (r_state == ST_RUN && stop)   w_stopPendingNext = 1'b1;
  end

  // State and status flags are registered from the next state, so cpu_run
  // drops on the very edge the FSM leaves RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_stopPending <= 1'b0;
      r_cpuRun      <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_stopPending <= w_stopPendingNext;
      r_cpuRun      <= (w_nextState == ST_RUN);
      r_halted      <= (w_nextState == ST_HALTED);
      r_fault       <= (w_nextState == ST_FAULT);
    end
  end

  step_counter u_stepCounter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_clear),
    .i_inc      (w_inc),
    .i_complete (w_complete),
    .o_step     (w_step),
    .o_count    (w_count)
  );

  assign step        = w_step;
  assign instr_count = w_count;
  assign cpu_run     = r_cpuRun;
  assign state_o     = r_state;
  assign halted      = r_halted;
  assign fault       = r_fault;

endmodule

// File: tb/tb_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_ctrl
// Directed stimulus for seq_ctrl with a behavioural reference model that is
// compared against the DUT on every falling clock edge, plus literal
// expectations at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_seq_ctrl;

  localparam logic [2:0] M_IDLE   = 3'd0;
  localparam logic [2:0] M_RUN    = 3'd1;
  localparam logic [2:0] M_PAUSE  = 3'd2;
  localparam logic [2:0] M_HALTED = 3'd3;
  localparam logic [2:0] M_FAULT  = 3'd4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        single_mode;
  logic        sc_inc;
  logic        sc_reset;
  logic        halt;
  logic [3:0]  step;
  logic        cpu_run;
  logic [2:0]  state_o;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  int checkCount = 0;
  int errorCount = 0;
  bit compareEnable = 1'b0;

  // Reference model state
  logic [2:0]  mState;
  logic [3:0]  mStep;
  logic [15:0] mCount;
  bit          mPending;

  seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .single_mode (single_mode),
    .sc_inc      (sc_inc),
    .sc_reset    (sc_reset),
    .halt        (halt),
    .step        (step),
    .cpu_run     (cpu_run),
    .state_o     (state_o),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count)
  );

  // 10-unit clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount + 1);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: applies the sequencer rules at each rising edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mState   = M_IDLE;
      mStep    = 4'd0;
      mCount   = 16'd0;
      mPending = 1'b0;
    end else if (mState == M_RUN) begin
      if (halt) begin
        mState = M_HALTED;
      end else if (sc_reset) begin
        mStep  = 4'd0;
        mCount = mCount + 16'd1;
        if (single_mode || mPending) mState = M_PAUSE;
      end else if (sc_inc) begin
        if (mStep == 4'd15) mState = M_FAULT;
        else                mStep  = mStep + 4'd1;
      end
      if (mState != M_RUN) mPending = 1'b0;
      else if (stop)       mPending = 1'b1;
    end else if (start && !stop) begin
      if (mState == M_HALTED || mState == M_FAULT) mStep = 4'd0;
      mState = M_RUN;
    end
  end

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n && compareEnable) begin
      checkOutput("model.state_o",     state_o,     mState);
      checkOutput("model.step",        step,        mStep);
      checkOutput("model.instr_count", instr_count, mCount);
      checkOutput("model.cpu_run",     cpu_run,     mState == M_RUN);
      checkOutput("model.halted",      halted,      mState == M_HALTED);
      checkOutput("model.fault",       fault,       mState == M_FAULT);
    end
  end

  // Drive one cycle of pulses at the falling edge; return just after the
  // following rising edge so outputs reflect this cycle's inputs.
  task automatic applyStimulus(input logic iStart, input logic iStop,
                               input logic iInc, input logic iScReset,
                               input logic iHalt);
    @(negedge clk);
    start    = iStart;
    stop     = iStop;
    sc_inc   = iInc;
    sc_reset = iScReset;
    halt     = iHalt;
    @(posedge clk);
    #1;
  endtask

  task automatic expectStatus(input string tag, input logic [2:0] st,
                              input logic [3:0] sp, input logic [15:0] cnt);
    checkOutput({tag, ".state_o"},     state_o,     st);
    checkOutput({tag, ".step"},        step,        sp);
    checkOutput({tag, ".instr_count"}, instr_count, cnt);
    checkOutput({tag, ".cpu_run"},     cpu_run,     st == M_RUN);
    checkOutput({tag, ".halted"},      halted,      st == M_HALTED);
    checkOutput({tag, ".fault"},       fault,       st == M_FAULT);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    single_mode = 1'b0;
    sc_inc      = 1'b0;
    sc_reset    = 1'b0;
    halt        = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    expectStatus("reset", M_IDLE, 4'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    compareEnable = 1'b1;

    // Idle ignores control-unit inputs
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 1);
    expectStatus("idleIgnore", M_IDLE, 4'd0, 16'd0);

    // Basic run: 7 steps then completion
    applyStimulus(1, 0, 0, 0, 0);
    expectStatus("basicStart", M_RUN, 4'd0, 16'd0);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("basicStep", step, i);
    end
    applyStimulus(0, 0, 0, 1, 0);
    expectStatus("basicDone", M_RUN, 4'd0, 16'd1);

    // Stop mid-instruction only takes effect at the boundary
    repeat (3) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    expectStatus("stopAt3", M_RUN, 4'd3, 16'd1);
    repeat (3) applyStimulus(0, 0, 1, 0, 0);
    expectStatus("stopAt6", M_RUN, 4'd6, 16'd1);
    applyStimulus(0, 0, 0, 1, 0);
    expectStatus("stopPause", M_PAUSE, 4'd0, 16'd2);
    applyStimulus(0, 0, 1, 0, 0);
    expectStatus("pauseIgnore", M_PAUSE, 4'd0, 16'd2);
    applyStimulus(1, 0, 0, 0, 0);
    expectStatus("resume", M_RUN, 4'd0, 16'd2);

    // Single-step mode
    single_mode = 1'b1;
    repeat (2) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    expectStatus("single1", M_PAUSE, 4'd0, 16'd3);
    applyStimulus(1, 0, 0, 0, 0);
    expectStatus("singleResume", M_RUN, 4'd0, 16'd3);
    applyStimulus(0, 0, 0, 1, 0);
    expectStatus("single2", M_PAUSE, 4'd0, 16'd4);
    // start and stop together: stop wins, no state change
    applyStimulus(1, 1, 0, 0, 0);
    expectStatus("startStop", M_PAUSE, 4'd0, 16'd4);
    single_mode = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    expectStatus("singleExit", M_RUN, 4'd0, 16'd4);

    // Halt outranks sc_reset
    repeat (5) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    expectStatus("halt", M_HALTED, 4'd5, 16'd4);
    applyStimulus(0, 0, 1, 0, 0);
    expectStatus("haltIgnore", M_HALTED, 4'd5, 16'd4);
    applyStimulus(1, 0, 0, 0, 0);
    expectStatus("haltRestart", M_RUN, 4'd0, 16'd4);

    // Step overflow goes to FAULT, never wraps
    repeat (15) applyStimulus(0, 0, 1, 0, 0);
    expectStatus("step15", M_RUN, 4'd15, 16'd4);
    applyStimulus(0, 0, 1, 0, 0);
    expectStatus("fault", M_FAULT, 4'd15, 16'd4);
    applyStimulus(1, 0, 0, 0, 0);
    expectStatus("faultRestart", M_RUN, 4'd0, 16'd4);

    // Async reset between edges
    repeat (4) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("preReset.step", step, 4'd4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expectStatus("asyncReset", M_IDLE, 4'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 1, 1, 0);
    expectStatus("postReset", M_IDLE, 4'd0, 16'd0);

    // Instruction counter wrap
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) applyStimulus(0, 0, 0, 1, 0);
    expectStatus("countMax", M_RUN, 4'd0, 16'hFFFF);
    applyStimulus(0, 0, 0, 1, 0);
    expectStatus("countWrap", M_RUN, 4'd0, 16'h0000);
    applyStimulus(0, 0, 1, 0, 0);
    expectStatus("afterWrap", M_RUN, 4'd1, 16'h0000);

    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
